modem_ctrl_regs: RTL
====================

# modem_ctrl_regs

Parametrised SPI register/RAM front-end for the modem transmit path. Decodes the byte-wide bus from the SPI slave into a message-RAM window plus a register bank, and owns the transmit handshake. Compared with the previous control block it adds:
- a two-state transmit FSM with abort;
- an optional watchdog timeout;
- sticky status flags with write-1-to-clear and a maskable interrupt;
- write lockout while busy, with a saturating reject counter.

## Interface
- ADDR_W, 10, SPI address width
- RAM_DEPTH, 1000, message RAM size; addresses below this are RAM
- REG_BASE, 1000, first register address; REG_BASE+23 must fit in ADDR_W
- LEN_W, 10, message length width, 9..16
- NUM_GPIO, 4, GPIO inputs, 1..7
- TIMEOUT_CYC, 1048576, watchdog limit in clk cycles, ≥2
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- i_spi_wr  in  1  one-cycle write strobe from SPI slave
- i_spi_rd  in  1  one-cycle read strobe from SPI slave
- i_spi_addr  in  ADDR_W  byte address
- i_spi_wdata  in  8  write data
- o_spi_rdata  out  8  read data, combinational from i_spi_addr
- i_ram_rdata  in  8  RAM read data
- o_ram_wr  out  1  RAM write strobe
- o_ram_rd  out  1  RAM read strobe
- o_ram_addr  out  ADDR_W  equals i_spi_addr
- o_ram_wdata  out  8  equals i_spi_wdata
- i_tx_done  in  1  modulator done pulse
- i_gpios  in  NUM_GPIO  status pins
- o_transmit  out  1  transmit request level
- o_msg_length  out  LEN_W  message length in bytes
- o_reg_cw  out  1  carrier-wave test mode
- o_irq  out  1  interrupt, active-high level

## Operation
- is_ram = i_spi_addr < RAM_DEPTH.
- o_ram_rd = i_spi_rd & is_ram.
- o_ram_wr = i_spi_wr & is_ram & ~busy.

Register map, offsets from REG_BASE:
- +0 LEN_HI: msg_length[LEN_W-1:8], zero-extended.
- +1 LEN_LO: msg_length[7:0].
- +2 STATUS:
  - bit0 done, sticky;
  - bit1 timeout, sticky;
  - bit2 busy, read-only;
  - writing 1 to bit0 or bit1 clears that bit.
- +3 IRQ_MASK: bits[1:0] enable done and timeout respectively.
- +4 REJECT: saturating 8-bit count, read-only; any write clears it.
- +5 CW: bit0 → o_reg_cw.
- +20 ID: reads 0x96.
- +21 VERSION: reads 0x02.
- +22 reads NUM_GPIO.
- +23 CTRL:
  - read {0, i_gpios, busy};
  - write bit0 = 1 starts a transmission;
  - write bit0 = 0 while BUSY aborts it.
- Unmapped register addresses read 0; writes to them are ignored.

FSM:
- States: IDLE, BUSY. o_transmit = (state == BUSY).
- IDLE → BUSY on a CTRL write with bit0 = 1 and msg_length ≠ 0.
  - With msg_length == 0 the state stays IDLE and REJECT increments.
- BUSY → IDLE in any of these cases:
  - done_d: sets done;
  - watchdog expiry: sets timeout;
  - CTRL write with bit0 = 0: no flag set.
- done_d is i_tx_done registered once. It is ignored in IDLE.

Lockout while BUSY:
- Writes to LEN_HI, LEN_LO, CW and RAM are dropped and increment REJECT.
- STATUS, IRQ_MASK, REJECT and CTRL writes remain accepted.

o_irq = |(STATUS[1:0] & IRQ_MASK), combinational from registers.

Priority when events coincide:
- done_d beats timeout and abort.
- Flag set beats W1C clear.
- REJECT clear plus increment in the same cycle → 1.
- REJECT holds at 255.

## Timing
- Reset: state IDLE; o_transmit, o_reg_cw, o_irq all 0; msg_length, STATUS, IRQ_MASK and REJECT all 0; watchdog counter 0.
- A register write at edge t is visible on outputs and read-back after edge t.
- A CTRL start at edge t drives o_transmit high from t.
- i_tx_done high before edge t:
  - done_d goes high at t;
  - state returns to IDLE and done is set at t+1;
  - o_transmit is therefore low 2 cycles after the pulse is sampled.
- Watchdog counter clears on entry to BUSY and increments each BUSY cycle. At count TIMEOUT_CYC-1 the block exits to IDLE, so o_transmit is high for exactly TIMEOUT_CYC cycles.
- Reset mid-transmission drops o_transmit on the next edge and clears all flags.

## Configuration
- MODEM_CTRL_TIMEOUT_EN defined: watchdog counter and timeout flag are built as described above.
- Not defined: no counter is built. BUSY exits only on done_d or abort, STATUS bit1 and IRQ_MASK bit1 read 0, and TIMEOUT_CYC is unused.

## Test plan
- Write LEN_HI=0x01 and LEN_LO=0x2C, then CTRL=0x01 → o_msg_length=300, o_transmit=1; a 1-cycle i_tx_done pulse → o_transmit=0 two cycles later; STATUS reads 0x01.
- IRQ_MASK=0x01 and a completed transmission → o_irq=1; write STATUS=0x01 → o_irq=0 next cycle; a W1C in the same cycle as done_d leaves done=1.
- While BUSY, write LEN_LO=0x10 and RAM addr 5 → o_msg_length unchanged, o_ram_wr never high, REJECT=2; 300 further rejects → REJECT=255.
- msg_length=0 and CTRL=0x01 → o_transmit stays 0, REJECT=1.
- TIMEOUT_CYC=16, MODEM_CTRL_TIMEOUT_EN defined, no done pulse → o_transmit high exactly 16 cycles, STATUS=0x02; done_d coinciding with expiry → STATUS=0x01.
- i_gpios=4'b1010 while BUSY → CTRL reads 0x15; ID reads 0x96; addr 999 returns i_ram_rdata; abort via CTRL=0x00 → IDLE, STATUS=0x00.

Source files
------------

// File: rtl/modem_ctrl_regs.sv
// SPI register/RAM front-end for the modem transmit path: message-RAM window,
// register bank and transmit FSM. Define MODEM_CTRL_TIMEOUT_EN to build the watchdog.
module modem_ctrl_regs #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned RAM_DEPTH   = 1000,
  parameter int unsigned REG_BASE    = 1000,
  parameter int unsigned LEN_W       = 10,
  parameter int unsigned NUM_GPIO    = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_spi_wr,
  input  logic                i_spi_rd,
  input  logic [ADDR_W-1:0]   i_spi_addr,
  input  logic [7:0]          i_spi_wdata,
  output logic [7:0]          o_spi_rdata,
  input  logic [7:0]          i_ram_rdata,
  output logic                o_ram_wr,
  output logic                o_ram_rd,
  output logic [ADDR_W-1:0]   o_ram_addr,
  output logic [7:0]          o_ram_wdata,
  input  logic                i_tx_done,
  input  logic [NUM_GPIO-1:0] i_gpios,
  output logic                o_transmit,
  output logic [LEN_W-1:0]    o_msg_length,
  output logic                o_reg_cw,
  output logic                o_irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [4:0] OFF_LEN_HI = 5'd0;
  localparam logic [4:0] OFF_LEN_LO = 5'd1;
  localparam logic [4:0] OFF_STATUS = 5'd2;
  localparam logic [4:0] OFF_MASK   = 5'd3;
  localparam logic [4:0] OFF_REJECT = 5'd4;
  localparam logic [4:0] OFF_CW     = 5'd5;
  localparam logic [4:0] OFF_ID     = 5'd20;
  localparam logic [4:0] OFF_VER    = 5'd21;
  localparam logic [4:0] OFF_NGPIO  = 5'd22;
  localparam logic [4:0] OFF_CTRL   = 5'd23;

`ifdef MODEM_CTRL_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic [0:0]       state;
  logic             busy;
  logic             done_d;
  logic [LEN_W-1:0] msg_length;
  logic             st_done;
  logic             st_timeout;
  logic [1:0]       irq_mask;
  logic [7:0]       reject;
  logic [7:0]       reject_nxt;
  logic [7:0]       reject_base;
  logic             reg_cw;
  logic             wd_expire;

  logic [31:0] addr32;
  logic        is_ram;
  logic        is_reg;
  logic [4:0]  reg_off;
  logic [7:0]  reg_rdata;

  logic wr_reg, wr_len_hi, wr_len_lo, wr_status, wr_mask, wr_reject, wr_cw, wr_ctrl;
  logic wr_ram, locked_wr;
  logic start_req, start_ok, start_rej, abort_req;
  logic set_done, set_to, go_idle, rej_inc;

  // ---------------- address decode ----------------
  assign addr32  = 32'(i_spi_addr);
  assign is_ram  = addr32 < RAM_DEPTH;
  assign is_reg  = (addr32 >= REG_BASE) && (addr32 <= REG_BASE + 23);
  assign reg_off = 5'(addr32 - REG_BASE);

  assign busy = (state == ST_BUSY);

  assign wr_reg    = i_spi_wr & is_reg;
  assign wr_len_hi = wr_reg & (reg_off == OFF_LEN_HI);
  assign wr_len_lo = wr_reg & (reg_off == OFF_LEN_LO);
  assign wr_status = wr_reg & (reg_off == OFF_STATUS);
  assign wr_mask   = wr_reg & (reg_off == OFF_MASK);
  assign wr_reject = wr_reg & (reg_off == OFF_REJECT);
  assign wr_cw     = wr_reg & (reg_off == OFF_CW);
  assign wr_ctrl   = wr_reg & (reg_off == OFF_CTRL);
  assign wr_ram    = i_spi_wr & is_ram;

  // Payload-affecting writes are frozen while a message is on the air
  assign locked_wr = busy & (wr_len_hi | wr_len_lo | wr_cw | wr_ram);

  assign o_ram_wr    = wr_ram & ~busy;
  assign o_ram_rd    = i_spi_rd & is_ram;
  assign o_ram_addr  = i_spi_addr;
  assign o_ram_wdata = i_spi_wdata;

  // ---------------- transmit control ----------------
  assign start_req = wr_ctrl & i_spi_wdata[0];
  assign start_ok  = start_req & ~busy & (msg_length != '0);
  assign start_rej = start_req & ~busy & (msg_length == '0);
  assign abort_req = wr_ctrl & ~i_spi_wdata[0] & busy;

  // done_d outranks watchdog expiry, both outrank abort
  assign set_done = busy & done_d;
  assign set_to   = busy & ~done_d & wd_expire;
  assign go_idle  = set_done | set_to | abort_req;
  assign rej_inc  = locked_wr | start_rej;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      done_d <= 1'b0;
    end else begin
      done_d <= i_tx_done;
      case (state)
        ST_IDLE: if (start_ok) state <= ST_BUSY;
        ST_BUSY: if (go_idle)  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MODEM_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd_cnt;

  // Held at zero while idle, so it starts from zero on every entry to BUSY
  always_ff @(posedge clk) begin
    if (reset || !busy) wd_cnt <= '0;
    else                wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_expire = busy & (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) st_timeout <= 1'b0;
    else       st_timeout <= set_to | (st_timeout & ~(wr_status & i_spi_wdata[1]));
  end
`else
  assign wd_expire  = 1'b0;
  assign st_timeout = 1'b0;
`endif

  // ---------------- register bank ----------------
  always_comb begin
    reject_base = wr_reject ? 8'h00 : reject;
    reject_nxt  = reject_base;
    if (rej_inc && reject_base != 8'hFF) reject_nxt = reject_base + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_length <= '0;
      st_done    <= 1'b0;
      irq_mask   <= 2'b00;
      reject     <= 8'h00;
      reg_cw     <= 1'b0;
    end else begin
      if (wr_len_hi && !busy) msg_length[LEN_W-1:8] <= i_spi_wdata[LEN_W-9:0];
      if (wr_len_lo && !busy) msg_length[7:0]       <= i_spi_wdata;
      if (wr_cw && !busy)     reg_cw                <= i_spi_wdata[0];
      if (wr_mask)            irq_mask              <= i_spi_wdata[1:0] & {TO_EN, 1'b1};
      st_done <= set_done | (st_done & ~(wr_status & i_spi_wdata[0]));
      reject  <= reject_nxt;
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_off)
      OFF_LEN_HI: reg_rdata = 8'(msg_length >> 8);
      OFF_LEN_LO: reg_rdata = msg_length[7:0];
      OFF_STATUS: reg_rdata = {5'b0, busy, st_timeout, st_done};
      OFF_MASK:   reg_rdata = {6'b0, irq_mask};
      OFF_REJECT: reg_rdata = reject;
      OFF_CW:     reg_rdata = {7'b0, reg_cw};
      OFF_ID:     reg_rdata = 8'h96;
      OFF_VER:    reg_rdata = 8'h02;
      OFF_NGPIO:  reg_rdata = 8'(NUM_GPIO);
      OFF_CTRL:   reg_rdata = 8'({i_gpios, busy});
      default:    reg_rdata = 8'h00;
    endcase
  end

  assign o_spi_rdata  = is_ram ? i_ram_rdata : (is_reg ? reg_rdata : 8'h00);
  assign o_transmit   = busy;
  assign o_msg_length = msg_length;
  assign o_reg_cw     = reg_cw;
  assign o_irq        = |({st_timeout, st_done} & irq_mask);

endmodule
